// File: rtl/rice_bus_ram_responder_if.sv
// Rice bus request/response channel bundle.
// The master modport drives requests; the slave modport answers them.
interface rice_bus_ram_responder_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                      request_valid;
    logic                      request_ready;
    logic [ADDRESS_WIDTH-1:0]  address;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic [DATA_WIDTH-1:0]     write_data;
    logic                      response_valid;
    logic                      response_ready;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      error;

    modport master (
        output request_valid, address, strobe, write_data, response_ready,
        input  request_ready, response_valid, read_data, error
    );

    modport slave (
        input  request_valid, address, strobe, write_data, response_ready,
        output request_ready, response_valid, read_data, error
    );
endinterface

// File: rtl/rice_bus_ram_responder.sv
// Rice bus RAM target: byte-strobed writes and word reads on a register-array memory,
// with one response per accepted request returned in order through a small FIFO.
module rice_bus_ram_responder #(
    parameter int unsigned     ADDRESS_WIDTH  = 32,
    parameter int unsigned     DATA_WIDTH     = 32,
    parameter longint unsigned BASE_ADDRESS   = 0,
    parameter int unsigned     SIZE           = 4096,
    parameter int unsigned     RESPONSE_DEPTH = 2,
    parameter string           INITIAL_FILE   = ""
) (
    input logic                     i_clk,
    input logic                     i_rst,
    rice_bus_ram_responder_if.slave slave_if
);
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned Words = SIZE / StrbW;
    localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned PtrW  = (RESPONSE_DEPTH > 1) ? $clog2(RESPONSE_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(RESPONSE_DEPTH + 1);

    // One extra bit so BASE_ADDRESS + SIZE may reach the top of the address space.
    localparam logic [ADDRESS_WIDTH:0]   BaseExt   = (ADDRESS_WIDTH + 1)'(BASE_ADDRESS);
    localparam logic [ADDRESS_WIDTH:0]   LimitExt  = (ADDRESS_WIDTH + 1)'(BASE_ADDRESS + SIZE);
    localparam logic [ADDRESS_WIDTH-1:0] AlignMask = ADDRESS_WIDTH'(StrbW - 1);

    logic [DATA_WIDTH-1:0] mem_q [Words];

    logic [DATA_WIDTH-1:0] rsp_data_q [RESPONSE_DEPTH];
    logic                  rsp_err_q  [RESPONSE_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic                     accept;
    logic                     pop;
    logic                     is_write;
    logic                     req_error;
    logic [ADDRESS_WIDTH:0]   addr_ext;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [IdxW-1:0]          req_idx;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    wr_word;
    logic [DATA_WIDTH-1:0]    push_data;
    logic                     push_err;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RESPONSE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on reset and occupancy, never on response_ready.
    assign slave_if.request_ready  = !i_rst && (count_q < CntW'(RESPONSE_DEPTH));
    assign slave_if.response_valid = (count_q != '0);
    assign slave_if.read_data      = slave_if.response_valid ? rsp_data_q[rd_ptr_q] : '0;
    assign slave_if.error          = slave_if.response_valid ? rsp_err_q[rd_ptr_q] : 1'b0;

    always_comb begin
        accept    = slave_if.request_valid && slave_if.request_ready;
        pop       = slave_if.response_valid && slave_if.response_ready;
        is_write  = |slave_if.strobe;
        addr_ext  = {1'b0, slave_if.address};
        req_error = (|(slave_if.address & AlignMask)) || (addr_ext < BaseExt)
                    || (addr_ext >= LimitExt);
        offset    = slave_if.address - BaseExt[ADDRESS_WIDTH-1:0];
        req_idx   = IdxW'(offset >> OffW);
        mem_rdata = mem_q[req_idx];

        wr_en   = accept && is_write && !req_error;
        wr_word = mem_rdata;
        for (int b = 0; b < int'(StrbW); b++) begin
            if (slave_if.strobe[b]) begin
                wr_word[8*b +: 8] = slave_if.write_data[8*b +: 8];
            end
        end

        push_data = (!req_error && !is_write) ? mem_rdata : '0;
        push_err  = req_error;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Memory and response storage carry no reset; writes survive a mid-operation reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[req_idx] <= wr_word;
        end
        if (accept) begin
            rsp_data_q[wr_ptr_q] <= push_data;
            rsp_err_q[wr_ptr_q]  <= push_err;
        end
    end
endmodule

// File: tb/tb_rice_bus_ram_responder.sv
// Randomised bench for rice_bus_ram_responder against a queue/array reference model.
module tb_rice_bus_ram_responder;
    localparam int unsigned Depth = 2;
    localparam int unsigned Size  = 4096;
    localparam logic [31:0] Base  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rice_bus_ram_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    rice_bus_ram_responder #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .BASE_ADDRESS  (64'h1000),
        .SIZE          (Size),
        .RESPONSE_DEPTH(Depth),
        .INITIAL_FILE  ("")
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .slave_if(bus_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] mdl_mem [int];
    logic [32:0] mdl_q [$];
    int          ok_words [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < Base) || ({1'b0, a} >= ({1'b0, Base} + 33'(Size)));
    endfunction

    task automatic step(input bit r, input bit v, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input bit rr, output bit accepted);
        bit          exp_ready;
        int          idx;
        logic [31:0] word;
        rst                   = r;
        bus_if.request_valid  = v;
        bus_if.address        = a;
        bus_if.strobe         = s;
        bus_if.write_data     = wd;
        bus_if.response_ready = rr;

        exp_ready = !r && (mdl_q.size() < Depth);
        accepted  = v && exp_ready;
        if (mdl_q.size() != 0 && rr) void'(mdl_q.pop_front());
        if (accepted) begin
            idx = int'((a - Base) >> 2);
            if (addr_err(a)) begin
                mdl_q.push_back({32'h0, 1'b1});
            end else if (s == 4'h0) begin
                mdl_q.push_back({mdl_mem[idx], 1'b0});
            end else begin
                word = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) word[8*b +: 8] = wd[8*b +: 8];
                end
                mdl_mem[idx] = word;
                mdl_q.push_back({32'h0, 1'b0});
            end
        end
        if (r) mdl_q.delete();

        @(posedge clk);
        @(negedge clk);
        check_val("request_ready", 32'(bus_if.request_ready),
                  32'(!rst && (mdl_q.size() < Depth)));
        check_val("response_valid", 32'(bus_if.response_valid), 32'(mdl_q.size() != 0));
        check_val("read_data", bus_if.read_data, (mdl_q.size() != 0) ? mdl_q[0][32:1] : 32'h0);
        check_val("error", 32'(bus_if.error), (mdl_q.size() != 0) ? 32'(mdl_q[0][0]) : 32'h0);
    endtask

    task automatic idle(input bit r, input bit rr);
        bit acc;
        step(r, 1'b0, Base, 4'h0, 32'h0, rr, acc);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input bit rr);
        bit acc;
        step(1'b0, 1'b1, a, s, d, rr, acc);
    endtask

    task automatic rd(input logic [31:0] a, input bit rr);
        bit acc;
        step(1'b0, 1'b1, a, 4'h0, 32'h0, rr, acc);
    endtask

    initial begin
        bit          acc;
        bit          cur_v;
        logic [31:0] cur_a;
        logic [3:0]  cur_s;
        logic [31:0] cur_d;
        bit          cur_rr;

        // Reset and idle
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);

        // Initialise the words the random phase may read.
        for (int i = 0; i < 16; i++) ok_words.push_back(i);
        ok_words.push_back(int'(Size / 4) - 1);
        foreach (ok_words[i]) wr(Base + 32'(ok_words[i] * 4), 4'hF, $urandom, 1'b1);
        idle(1'b0, 1'b1);

        // Back-to-back write then read
        wr(Base + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1);
        check_val("b2b_wr_rsp", bus_if.read_data, 32'h0);
        rd(Base + 32'h10, 1'b1);
        check_val("b2b_rd_rsp", bus_if.read_data, 32'hDEAD_BEEF);
        idle(1'b0, 1'b1);

        // Partial strobe
        wr(Base + 32'h20, 4'hF, 32'hAABB_CCDD, 1'b1);
        wr(Base + 32'h20, 4'b0101, 32'h1122_3344, 1'b1);
        rd(Base + 32'h20, 1'b1);
        check_val("partial_rd", bus_if.read_data, 32'hAA22_CC44);
        idle(1'b0, 1'b1);

        // Error cases
        rd(Base + 32'h2, 1'b1);
        check_val("err_misaligned", 32'(bus_if.error), 32'h1);
        rd(Base + Size, 1'b1);
        check_val("err_above", 32'(bus_if.error), 32'h1);
        wr(Base - 32'h4, 4'hF, 32'h5555_5555, 1'b1);
        check_val("err_below", 32'(bus_if.error), 32'h1);
        rd(Base, 1'b1);
        idle(1'b0, 1'b1);

        // Backpressure: third read stalls until a pop frees a slot
        rd(Base + 32'h10, 1'b0);
        rd(Base + 32'h14, 1'b0);
        rd(Base + 32'h18, 1'b0);
        rd(Base + 32'h18, 1'b1);
        rd(Base + 32'h18, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);

        // Reset with two responses pending
        wr(Base + 32'h30, 4'hF, 32'hCAFE_F00D, 1'b0);
        rd(Base + 32'h10, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        rd(Base + 32'h30, 1'b1);
        check_val("persist_after_rst", bus_if.read_data, 32'hCAFE_F00D);
        idle(1'b0, 1'b1);

        // Random traffic; a request is held until accepted
        cur_v = 1'b0;
        cur_a = Base;
        cur_s = 4'h0;
        cur_d = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 19))
                    0:       cur_a = Base + 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                    1:       cur_a = Base - 32'($urandom_range(1, 64) * 4);
                    2:       cur_a = Base + Size + 32'($urandom_range(0, 64) * 4);
                    default: cur_a = Base + 32'(ok_words[$urandom_range(0, ok_words.size() - 1)] * 4);
                endcase
                cur_s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                cur_d = $urandom;
            end
            cur_rr = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) begin
                idle(1'b1, cur_rr);
            end else begin
                step(1'b0, cur_v, cur_a, cur_s, cur_d, cur_rr, acc);
                if (acc) cur_v = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
